// File: rtl/avalon_st_packet_arbiter_pkg.sv
// Shared types for the Avalon-ST packet arbiter: beat record, arbiter state
// and the channel-width helper.
package avalon_st_pkg;

    localparam int BEAT_DATA_WIDTH  = 32;
    localparam int BEAT_EMPTY_WIDTH = 2;

    typedef struct packed {
        logic [BEAT_DATA_WIDTH-1:0]  data;
        logic                        sop;
        logic                        eop;
        logic [BEAT_EMPTY_WIDTH-1:0] empty;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A channel index always needs at least one bit, even for two sources.
    function automatic int ch_width(input int num_inputs);
        return (num_inputs <= 2) ? 1 : $clog2(num_inputs);
    endfunction

endpackage

// File: rtl/avalon_st_packet_arbiter_if.sv
// Bundle of the N source streams, the shared sink stream and the error flag.
// The master modport is the arbiter side; slave is the environment side.
interface avalon_st_packet_arbiter_if #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    parameter int CH_WIDTH    = 2
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data;
    logic [NUM_INPUTS-1:0]             in_valid;
    logic [NUM_INPUTS-1:0]             in_ready;
    logic [NUM_INPUTS-1:0]             in_sop;
    logic [NUM_INPUTS-1:0]             in_eop;
    logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_sop;
    logic                              out_eop;
    logic [EMPTY_WIDTH-1:0]            out_empty;
    logic [CH_WIDTH-1:0]               out_channel;
    logic                              err_protocol;

    modport master (
        input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
               out_channel, err_protocol
    );

    modport slave (
        output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
               out_channel, err_protocol
    );
endinterface

// File: rtl/avalon_st_packet_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after 'last',
// wrapping modulo NUM_INPUTS.
module rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int CH_WIDTH   = 2
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [CH_WIDTH-1:0]   last,
    output logic [CH_WIDTH-1:0]   gnt_idx,
    output logic                  any_req
);
    logic [CH_WIDTH-1:0] cand_idx [NUM_INPUTS];

    // cand_idx[gi] is the source examined at priority position gi.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_cand
            assign cand_idx[gi] = CH_WIDTH'((int'(last) + gi + 1) % NUM_INPUTS);
        end
    endgenerate

    // Scan from lowest priority upward so the highest-priority hit wins.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                gnt_idx = cand_idx[k];
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-granular round-robin arbiter: one source owns the sink from SOP to
// EOP; one IDLE cycle per packet is spent choosing the next owner.
module avalon_st_packet_arbiter
    import avalon_st_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    parameter int CH_WIDTH    = ch_width(NUM_INPUTS)
) (
    input  logic clk,
    input  logic reset,
    avalon_st_packet_arbiter_if.master bus
);
    arb_state_t          state_reg, state_next;
    logic [CH_WIDTH-1:0] grant_reg, grant_next;
    logic [CH_WIDTH-1:0] last_grant_reg, last_grant_next;
    logic                first_beat_reg, first_beat_next;
    logic                err_reg, err_next;

    logic [CH_WIDTH-1:0]    pick_idx;
    logic                   any_req;
    logic                   locked;
    logic                   valid_mux;
    logic                   sop_mux;
    logic                   eop_mux;
    logic                   beat_xfer;
    logic [DATA_WIDTH-1:0]  data_arr  [NUM_INPUTS];
    logic [EMPTY_WIDTH-1:0] empty_arr [NUM_INPUTS];

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .CH_WIDTH   (CH_WIDTH)
    ) u_rr (
        .req     (bus.in_valid),
        .last    (last_grant_reg),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    assign locked = (state_reg == LOCKED);

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_src
            assign data_arr[gi]     = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign empty_arr[gi]    = bus.in_empty[gi*EMPTY_WIDTH +: EMPTY_WIDTH];
            assign bus.in_ready[gi] = locked && (grant_reg == CH_WIDTH'(gi)) && bus.out_ready;
        end
    endgenerate

    assign valid_mux = locked && bus.in_valid[grant_reg];
    assign sop_mux   = bus.in_sop[grant_reg];
    assign eop_mux   = bus.in_eop[grant_reg];
    assign beat_xfer = valid_mux && bus.out_ready;

    assign bus.out_valid    = valid_mux;
    assign bus.out_data     = data_arr[grant_reg];
    assign bus.out_sop      = sop_mux;
    assign bus.out_eop      = eop_mux;
    assign bus.out_empty    = empty_arr[grant_reg];
    assign bus.out_channel  = grant_reg;
    assign bus.err_protocol = err_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        first_beat_next = first_beat_reg;
        err_next        = err_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next      = pick_idx;
                    first_beat_next = 1'b1;
                    state_next      = LOCKED;
                end
            end
            LOCKED: begin
                if (beat_xfer) begin
                    // SOP must be set on exactly the first beat of the grant.
                    if (sop_mux != first_beat_reg) begin
                        err_next = 1'b1;
                    end
                    first_beat_next = 1'b0;
                    if (eop_mux) begin
                        last_grant_next = grant_reg;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= CH_WIDTH'(NUM_INPUTS - 1);
            first_beat_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            first_beat_reg <= first_beat_next;
            err_reg        <= err_next;
        end
    end
endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Self-checking bench: scenario table, random packet traffic against a
// packet-level round-robin model, and hand-written error/reset sequences.
`timescale 1ns/1ps
module tb_avalon_st_packet_arbiter;
    import avalon_st_pkg::*;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int EW     = 2;
    localparam int CW     = 2;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avalon_st_packet_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CH_WIDTH(CW)) bus();

    avalon_st_packet_arbiter #(
        .NUM_INPUTS (N),
        .DATA_WIDTH (DW),
        .EMPTY_WIDTH(EW),
        .CH_WIDTH   (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] npkt;   // packets per source, one nibble each, source 0 leftmost
        int          len;    // beats per packet, 0 = random 1..8
        logic [15:0] dly;    // cycles before each source starts, source 0 leftmost
        bit          bp;     // random out_ready backpressure
        int          n_ord;
        logic [47:0] ord;    // expected channel order, first packet leftmost
    } vec_t;

    localparam int NVEC = 5;
    vec_t vecs [NVEC];

    beat_t src_q [N][$];
    beat_t exp_q [N][$];
    int    ord_q [$];
    int    exp_ord [$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int nib(input logic [47:0] v, input int idx);
        return int'(v[idx*4 +: 4]);
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.in_sop    = '0;
        bus.in_eop    = '0;
        bus.in_data   = '0;
        bus.in_empty  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] d, input logic sop, input logic eop, input logic v);
        bus.in_data[i*DW +: DW] = d;
        bus.in_sop[i]           = sop;
        bus.in_eop[i]           = eop;
        bus.in_empty[i*EW +: EW] = '0;
        bus.in_valid[i]         = v;
    endtask

    task automatic load_packets(input int np[N], input int len);
        beat_t b;
        int    l;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            for (int p = 0; p < np[i]; p++) begin
                l = (len > 0) ? len : int'($urandom_range(1, 8));
                for (int k = 0; k < l; k++) begin
                    b.data  = $urandom;
                    b.sop   = (k == 0);
                    b.eop   = (k == l - 1);
                    b.empty = b.eop ? EW'($urandom_range(0, 3)) : '0;
                    src_q[i].push_back(b);
                    exp_q[i].push_back(b);
                end
            end
        end
    endtask

    // Packet-level round robin: next owner is the first source after the
    // previous owner that still has packets queued.
    function automatic void model_order(input int np[N]);
        int rem [N];
        int last;
        int left;
        int idx;
        exp_ord.delete();
        left = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = np[i];
            left += np[i];
        end
        last = N - 1;
        while (left > 0) begin
            for (int off = 1; off <= N; off++) begin
                idx = (last + off) % N;
                if (rem[idx] > 0) begin
                    exp_ord.push_back(idx);
                    rem[idx]--;
                    left--;
                    last = idx;
                    break;
                end
            end
        end
    endfunction

    task automatic drive_sources(input int k, input int dly[N], input bit bp, input bit gaps);
        beat_t b;
        logic  v;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && k >= dly[i]) begin
                b = src_q[i][0];
                v = b.sop || !gaps || ($urandom_range(0, 2) != 0);
            end else begin
                b = '0;
                v = 1'b0;
            end
            bus.in_valid[i]          = v;
            bus.in_sop[i]            = b.sop;
            bus.in_eop[i]            = b.eop;
            bus.in_data[i*DW +: DW]  = b.data;
            bus.in_empty[i*EW +: EW] = b.empty;
        end
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    function automatic bit sources_pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_engine(input int dly[N], input bit bp, input bit gaps,
                              output int first_sop, output int last_eop);
        int    k;
        int    c;
        int    cur_ch;
        int    nbeats;
        bit    in_pkt;
        bit    busy;
        bit    bad;
        bit    xin [N];
        beat_t e;
        int    left;
        k = 0; cur_ch = 0; nbeats = 0; in_pkt = 1'b0;
        first_sop = -1; last_eop = -1;
        ord_q.delete();
        drive_sources(k, dly, bp, gaps);
        busy = sources_pending();
        while (busy) begin
            @(negedge clk);
            bad = 1'b0;
            for (int i = 0; i < N; i++) begin
                xin[i] = bus.in_valid[i] && bus.in_ready[i];
                if (i != int'(bus.out_channel) && bus.in_ready[i]) bad = 1'b1;
            end
            chk("in_ready exclusive", 64'(bad), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                c = int'(bus.out_channel);
                if (exp_q[c].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected beat: channel %0d sent a beat, required none", c);
                end else begin
                    e = exp_q[c].pop_front();
                    chk("beat", 64'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_empty}), 64'(e));
                    if (bus.out_sop) begin
                        chk("sop inside packet", 64'(in_pkt), 64'd0);
                        ord_q.push_back(c);
                        if (first_sop < 0) first_sop = k;
                        in_pkt = 1'b1; cur_ch = c; nbeats = 0;
                    end else begin
                        chk("contiguous channel", 64'(c), 64'(cur_ch));
                    end
                    nbeats++;
                    if (bus.out_eop) begin
                        in_pkt = 1'b0; last_eop = k;
                        $display("packet ch=%0d beats=%0d end_cycle=%0d", c, nbeats, k);
                    end
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (xin[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            k++;
            busy = sources_pending();
            if (busy && k > BUDGET) begin
                checks++; errors++;
                $display("FAIL timeout: %0d cycles used, required at most %0d", k, BUDGET);
                busy = 1'b0;
            end else begin
                drive_sources(k, dly, bp, gaps);
            end
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        chk("beats not delivered", 64'(left), 64'd0);
    endtask

    task automatic check_order(input string name, input int n, input logic [47:0] ord, input bit use_model);
        int expv;
        chk({name, " packet count"}, 64'(ord_q.size()), 64'(n));
        for (int j = 0; j < n; j++) begin
            expv = use_model ? exp_ord[j] : nib(ord, n - 1 - j);
            chk({name, " channel order"}, (j < ord_q.size()) ? 64'(ord_q[j]) : 64'hFFFF, 64'(expv));
        end
    endtask

    task automatic wait_out(input string name);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: no transfer within 10 cycles, required one", name);
        end
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np [N];
        int dz [N];
        int fs;
        int le;
        int tot;
        int nb;
        logic xf;

        vecs[0] = '{16'h1000, 20, 16'h0000, 1'b0, 1,  48'h0};
        vecs[1] = '{16'h2222, 3,  16'h0000, 1'b0, 8,  48'h01230123};
        vecs[2] = '{16'h5005, 1,  16'h0000, 1'b0, 10, 48'h0303030303};
        vecs[3] = '{16'h0110, 17, 16'h0400, 1'b1, 2,  48'h21};
        vecs[4] = '{16'h0330, 2,  16'h0000, 1'b0, 6,  48'h121212};

        do_reset();
        @(negedge clk);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset out_channel", 64'(bus.out_channel), 64'd0);
        chk("reset err_protocol", 64'(bus.err_protocol), 64'd0);
        @(posedge clk); #1;

        for (int r = 0; r < NVEC; r++) begin
            int dl [N];
            tot = 0;
            for (int i = 0; i < N; i++) begin
                np[i] = nib(48'(vecs[r].npkt), N - 1 - i);
                dl[i] = nib(48'(vecs[r].dly), N - 1 - i);
                tot += np[i];
            end
            do_reset();
            load_packets(np, vecs[r].len);
            run_engine(dl, vecs[r].bp, 1'b0, fs, le);
            check_order($sformatf("row%0d", r), vecs[r].n_ord, vecs[r].ord, 1'b0);
            if (!vecs[r].bp && vecs[r].dly == 16'h0) begin
                chk($sformatf("row%0d first sop cycle", r), 64'(fs), 64'd1);
                chk($sformatf("row%0d last eop cycle", r), 64'(le), 64'(tot * (vecs[r].len + 1) - 1));
            end
            chk($sformatf("row%0d err_protocol", r), 64'(bus.err_protocol), 64'd0);
        end

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                np[i] = int'($urandom_range(0, 3));
                dz[i] = 0;
            end
            do_reset();
            load_packets(np, 0);
            model_order(np);
            run_engine(dz, it[0], 1'b1, fs, le);
            check_order($sformatf("rand%0d", it), exp_ord.size(), 48'h0, 1'b1);
            chk($sformatf("rand%0d err_protocol", it), 64'(bus.err_protocol), 64'd0);
        end

        // First beat of a grant without SOP.
        do_reset();
        bus.out_ready = 1'b1;
        set_src(1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1);
        wait_out("missing sop transfer");
        chk("missing sop err before", 64'(bus.err_protocol), 64'd0);
        chk("missing sop data", 64'(bus.out_data), 64'hA5A5_0001);
        chk("missing sop channel", 64'(bus.out_channel), 64'd1);
        @(posedge clk); #1;
        set_src(1, 32'hA5A5_0002, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("missing sop err after", 64'(bus.err_protocol), 64'd1);
        chk("missing sop data beat2", 64'(bus.out_data), 64'hA5A5_0002);
        @(posedge clk); #1;
        bus.in_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err sticky", 64'(bus.err_protocol), 64'd1);
        @(posedge clk); #1;

        // SOP repeated mid-packet.
        do_reset();
        bus.out_ready = 1'b1;
        set_src(0, 32'h1111_0000, 1'b1, 1'b0, 1'b1);
        wait_out("repeat sop transfer");
        chk("repeat sop err first beat", 64'(bus.err_protocol), 64'd0);
        @(posedge clk); #1;
        set_src(0, 32'h1111_0001, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("repeat sop beat passes", 64'(bus.out_valid && bus.out_data == 32'h1111_0001), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = '0;
        @(negedge clk);
        chk("repeat sop err", 64'(bus.err_protocol), 64'd1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("err cleared by reset", 64'(bus.err_protocol), 64'd0);
        @(posedge clk); #1;

        // Reset while source 2 is mid-packet.
        do_reset();
        bus.out_ready = 1'b1;
        nb = 0;
        set_src(2, 32'h2000_0000, 1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 40 && nb < 7; t++) begin
            @(negedge clk);
            xf = bus.out_valid && bus.out_ready;
            @(posedge clk); #1;
            if (xf) begin
                nb++;
                set_src(2, 32'h2000_0000 + 32'(nb), 1'b0, (nb == 19), 1'b1);
            end
        end
        chk("beats before mid reset", 64'(nb), 64'd7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = '0;
        @(negedge clk);
        chk("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid reset in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid reset err_protocol", 64'(bus.err_protocol), 64'd0);
        @(posedge clk); #1;
        np[0] = 1; np[1] = 1; np[2] = 0; np[3] = 0;
        for (int i = 0; i < N; i++) dz[i] = 0;
        load_packets(np, 5);
        run_engine(dz, 1'b0, 1'b0, fs, le);
        check_order("after mid reset", 2, 48'h01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avalon_st_packet_arbiter.md
Name: avalon_st_packet_arbiter

Overview:
Packet-granular round-robin arbiter that shares one Avalon-ST sink between NUM_INPUTS Avalon-ST sources. Once a source wins, it owns the output from SOP through EOP, so packets never interleave. It sits in front of shared streaming resources such as a checker, a FIFO or a MAC transmit path. The bench drives it with packet_pkg::Packet objects and checks that every output packet equals one input packet.

Parameters:
NUM_INPUTS, 4, number of requesting sources (2..16)
DATA_WIDTH, 32, symbol data bits per beat
EMPTY_WIDTH, 2, width of the empty field, equal to log2(DATA_WIDTH/8)
CH_WIDTH, 2, width of out_channel, equal to max(1, log2(NUM_INPUTS))

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
in_data  in  NUM_INPUTS*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  NUM_INPUTS  per-source valid
in_ready  out  NUM_INPUTS  per-source ready
in_sop  in  NUM_INPUTS  per-source start of packet
in_eop  in  NUM_INPUTS  per-source end of packet
in_empty  in  NUM_INPUTS*EMPTY_WIDTH  per-source empty field
out_data  out  DATA_WIDTH  muxed data
out_valid  out  1  muxed valid
out_ready  in  1  sink ready
out_sop  out  1  muxed start of packet
out_eop  out  1  muxed end of packet
out_empty  out  EMPTY_WIDTH  muxed empty field
out_channel  out  CH_WIDTH  index of the granted source
err_protocol  out  1  sticky error; cleared only by reset

Behaviour:
- Handshake: a beat transfers when valid and ready are both high in the same cycle. Ready latency is 0.
- State machine: two states, IDLE and LOCKED, with registers grant[CH_WIDTH] and last_grant[CH_WIDTH].
- Reset: state goes to IDLE, grant = 0, last_grant = NUM_INPUTS-1 (source 0 has first priority), err_protocol = 0.
- Outputs after reset: out_valid = 0, in_ready = all 0, out_channel = 0. out_data, out_sop, out_eop and out_empty are don't-care while out_valid = 0.
- IDLE:
  - in_ready = all 0 and out_valid = 0.
  - If any in_valid bit is high, grant takes the first valid index found by searching upward from last_grant+1, wrapping modulo NUM_INPUTS. State goes to LOCKED.
  - Arbitration costs exactly one idle cycle per packet.
- LOCKED:
  - out_* come from source grant through a combinational mux.
  - out_valid = in_valid[grant].
  - in_ready[grant] = out_ready; all other in_ready bits are 0.
  - out_channel = grant.
- End of packet: on a transfer with out_eop = 1, last_grant takes grant and state returns to IDLE on the next cycle. This also applies to a single-beat packet (sop and eop both high).
- Protocol errors set err_protocol; the beat still passes through unchanged:
  - the first transfer after entering LOCKED has sop = 0;
  - any later transfer within the same packet has sop = 1.
- Backpressure: out_ready = 0 while LOCKED holds the grant indefinitely. A granted source that drops in_valid mid-packet also keeps the grant; there is no timeout.
- Fairness: any source with a pending packet waits at most NUM_INPUTS-1 packets.
- Reset mid-packet: the partial packet is abandoned and state goes to IDLE on the next cycle. The sink must tolerate a truncated packet.
- Requests arriving in the same cycle are resolved by the round-robin order only. A source raising valid in the cycle that the current grant's EOP transfers is considered in the following IDLE cycle.

Decomposition:
- The shared package avalon_st_pkg holds:
  - the beat struct typedef (data, sop, eop, empty);
  - the state enum (IDLE, LOCKED);
  - a function that computes CH_WIDTH.
- One sub-module: rr_arbiter. It is a combinational round-robin picker with inputs req[NUM_INPUTS] and last[CH_WIDTH], and outputs gnt_idx and any_req. It is reusable by other schedulers.

Test Plan:
- Single source: source 0 sends a 20-beat random Packet, out_ready = 1. Expect one idle cycle, then 20 beats on the output with out_channel = 0. The captured packet is_packet_equal to the sent packet, and err_protocol = 0.
- Fairness: all 4 sources continuously send 3-beat packets. The output channel order after reset is 0,1,2,3,0,1,… Every packet is contiguous and each takes 4 cycles (1 idle + 3 beats).
- Backpressure: out_ready is toggled randomly at 50% while source 2 sends 17 beats and source 1 is pending. No beat from source 1 appears until source 2's EOP transfers; the output packet equals the input and in_ready[1] stays 0 throughout.
- Single-beat packets: sources 0 and 3 each send 5 packets with sop = eop = 1. The output alternates 0,3,0,3,… with 10 beats total.
- Protocol error: source 1's first beat has sop = 0. err_protocol is 1 from the cycle after that transfer and stays 1 until reset; data still passes through.
- Mid-packet reset: assert reset at beat 7 of 20 from source 2. On the cycle after reset: out_valid = 0, in_ready = 0, err_protocol = 0. Then source 0 sends a packet and is granted first.
